// File: rtl/brownout_pkg.sv
// Shared types and default tuning constants for the brownout sequencer.
// Also holds the drop helper used by the evaluation step.
package brownout_pkg;

  localparam int unsigned DATA_W = 8;

  localparam int unsigned DEF_SAMPLE_PERIOD = 4;
  localparam int unsigned DEF_RATE_THRESH   = 7;
  localparam int unsigned DEF_TRIP_COUNT    = 2;
  localparam int unsigned DEF_RECOVER_LEVEL = 200;
  localparam int unsigned DEF_RECOVER_COUNT = 3;
  localparam int unsigned DEF_ADC_TIMEOUT   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EVAL = 2'd2
  } state_t;

  // Voltage drop between two samples; zero without a valid previous sample or on a rise.
  function automatic logic [DATA_W-1:0] calc_drop(input logic [DATA_W-1:0] prev_sample,
                                                  input logic [DATA_W-1:0] cur_sample,
                                                  input logic              prev_ok);
    if (prev_ok && (prev_sample > cur_sample)) begin
      return prev_sample - cur_sample;
    end
    return '0;
  endfunction

endpackage

// File: rtl/brownout_timer.sv
// Up-counter with synchronous clear; last_c flags the final cycle of a LIMIT-cycle window.
// Used for both the sample period and the ADC response timeout.
module brownout_timer #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last_c
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign last_c = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/brownout_sequencer.sv
// Periodically samples a supply ADC, flags brownout on repeated fast voltage drops,
// and clears it after a run of samples back above the recovery level.
module brownout_sequencer
  import brownout_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int unsigned RATE_THRESH   = DEF_RATE_THRESH,
  parameter int unsigned TRIP_COUNT    = DEF_TRIP_COUNT,
  parameter int unsigned RECOVER_LEVEL = DEF_RECOVER_LEVEL,
  parameter int unsigned RECOVER_COUNT = DEF_RECOVER_COUNT,
  parameter int unsigned ADC_TIMEOUT   = DEF_ADC_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic              adc_req,
  output logic              brownout,
  output logic              adc_fault,
  output logic [DATA_W-1:0] last_drop
);

  localparam int unsigned VW = $clog2(TRIP_COUNT + 1);
  localparam int unsigned RW = $clog2(RECOVER_COUNT + 1);
  localparam logic [DATA_W-1:0] THRESH    = DATA_W'(RATE_THRESH);
  localparam logic [DATA_W-1:0] REC_LEVEL = DATA_W'(RECOVER_LEVEL);

  state_t            state;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic [VW-1:0]     viol_cnt;
  logic [RW-1:0]     rec_cnt;

  logic              per_last_c;
  logic              to_last_c;
  logic              per_clear_c;
  logic              to_clear_c;
  logic [DATA_W-1:0] drop_c;
  logic [VW-1:0]     viol_next_c;
  logic              rec_hit_c;

  // Each timer only runs while its own state is active and restarts on every exit.
  assign per_clear_c = !enable || (state != IDLE) || per_last_c;
  assign to_clear_c  = !enable || (state != REQ) || to_last_c || adc_valid;

  brownout_timer #(.LIMIT(SAMPLE_PERIOD)) u_period (
    .clk    (clk),
    .rst    (rst),
    .clear  (per_clear_c),
    .en     (1'b1),
    .last_c (per_last_c)
  );

  brownout_timer #(.LIMIT(ADC_TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear_c),
    .en     (1'b1),
    .last_c (to_last_c)
  );

  // Evaluation of the captured sample against the previous one.
  always_comb begin
    drop_c      = calc_drop(prev, cur, prev_valid);
    viol_next_c = '0;
    if (drop_c > THRESH) begin
      viol_next_c = (viol_cnt == VW'(TRIP_COUNT)) ? viol_cnt : viol_cnt + 1'b1;
    end
    rec_hit_c = (cur >= REC_LEVEL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      adc_req    <= 1'b0;
      brownout   <= 1'b0;
      adc_fault  <= 1'b0;
      last_drop  <= '0;
      cur        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      viol_cnt   <= '0;
      rec_cnt    <= '0;
    end else if (!enable) begin
      // last_drop deliberately holds across a disable.
      state      <= IDLE;
      adc_req    <= 1'b0;
      brownout   <= 1'b0;
      adc_fault  <= 1'b0;
      prev_valid <= 1'b0;
      viol_cnt   <= '0;
      rec_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (per_last_c) begin
            state   <= REQ;
            adc_req <= 1'b1;
          end
        end
        REQ: begin
          // A strobe in the timeout cycle still wins over the fault.
          if (adc_valid) begin
            cur     <= adc_data;
            adc_req <= 1'b0;
            state   <= EVAL;
          end else if (to_last_c) begin
            adc_fault <= 1'b1;
            adc_req   <= 1'b0;
            state     <= IDLE;
          end
        end
        EVAL: begin
          last_drop  <= drop_c;
          prev       <= cur;
          prev_valid <= 1'b1;
          state      <= IDLE;
          if (brownout && rec_hit_c && (rec_cnt == RW'(RECOVER_COUNT - 1))) begin
            brownout <= 1'b0;
            viol_cnt <= '0;
            rec_cnt  <= '0;
          end else begin
            viol_cnt <= viol_next_c;
            rec_cnt  <= (brownout && rec_hit_c) ? rec_cnt + 1'b1 : '0;
            if (!brownout && (viol_next_c == VW'(TRIP_COUNT))) begin
              brownout <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          adc_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brownout_sequencer.sv
// Directed bench for brownout_sequencer at default parameters.
// Inputs change and outputs are checked on the falling clock edge.
module tb_brownout_sequencer;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic       adc_req;
  logic       brownout;
  logic       adc_fault;
  logic [7:0] last_drop;

  int checks = 0;
  int errors = 0;

  brownout_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .adc_req   (adc_req),
    .brownout  (brownout),
    .adc_fault (adc_fault),
    .last_drop (last_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the sequencer to raise its request.
  task automatic wait_req();
    int n;
    n = 0;
    while (adc_req !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
    end
    chk("req_wait", 32'(adc_req), 32'd1);
  endtask

  // Answer one request; returns on the falling edge after the evaluation cycle.
  task automatic sample(input logic [7:0] v);
    wait_req();
    adc_data  = v;
    adc_valid = 1'b1;
    cyc(1);
    adc_valid = 1'b0;
    cyc(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    adc_data  = 8'd0;
    adc_valid = 1'b0;
    cyc(2);
    chk("rst_req", 32'(adc_req), 32'd0);
    chk("rst_bo", 32'(brownout), 32'd0);
    chk("rst_fault", 32'(adc_fault), 32'd0);
    chk("rst_drop", 32'(last_drop), 32'd0);
    rst    = 1'b0;
    enable = 1'b1;

    // Falling supply 250,240,230 trips brownout two cycles after the third strobe.
    sample(8'd250);
    chk("first_drop", 32'(last_drop), 32'd0);
    sample(8'd240);
    chk("drop10_a", 32'(last_drop), 32'd10);
    chk("bo_after_one", 32'(brownout), 32'd0);
    wait_req();
    adc_data  = 8'd230;
    adc_valid = 1'b1;
    cyc(1);
    adc_valid = 1'b0;
    chk("bo_lat1", 32'(brownout), 32'd0);
    chk("req_drop_on_valid", 32'(adc_req), 32'd0);
    cyc(1);
    chk("bo_lat2", 32'(brownout), 32'd1);
    chk("drop10_b", 32'(last_drop), 32'd10);

    // Recovery: 199 breaks the run, so it ends only after 203.
    sample(8'd210);
    chk("rec_210", 32'(brownout), 32'd1);
    sample(8'd205);
    chk("rec_205", 32'(brownout), 32'd1);
    sample(8'd199);
    chk("rec_199", 32'(brownout), 32'd1);
    chk("rec_199_drop", 32'(last_drop), 32'd6);
    sample(8'd201);
    chk("rec_201", 32'(brownout), 32'd1);
    sample(8'd202);
    chk("rec_202", 32'(brownout), 32'd1);
    sample(8'd203);
    chk("rec_203", 32'(brownout), 32'd0);
    chk("rec_203_drop", 32'(last_drop), 32'd0);

    // Drops of exactly the threshold never trip.
    sample(8'd250);
    sample(8'd243);
    chk("thr_drop7_a", 32'(last_drop), 32'd7);
    chk("thr_bo_a", 32'(brownout), 32'd0);
    sample(8'd236);
    chk("thr_drop7_b", 32'(last_drop), 32'd7);
    chk("thr_bo_b", 32'(brownout), 32'd0);

    // Strobe in the last timeout cycle is accepted.
    wait_req();
    cyc(15);
    chk("to16_req", 32'(adc_req), 32'd1);
    adc_data  = 8'd230;
    adc_valid = 1'b1;
    cyc(1);
    adc_valid = 1'b0;
    chk("to16_fault", 32'(adc_fault), 32'd0);
    chk("to16_req_low", 32'(adc_req), 32'd0);
    cyc(1);
    chk("to16_drop", 32'(last_drop), 32'd6);
    chk("to16_fault2", 32'(adc_fault), 32'd0);

    // No strobe at all: fault after 16 request cycles, sample skipped.
    wait_req();
    cyc(15);
    chk("to_pre_req", 32'(adc_req), 32'd1);
    chk("to_pre_fault", 32'(adc_fault), 32'd0);
    cyc(1);
    chk("to_fault", 32'(adc_fault), 32'd1);
    chk("to_req", 32'(adc_req), 32'd0);
    sample(8'd225);
    chk("to_skip_drop", 32'(last_drop), 32'd5);
    chk("to_sticky", 32'(adc_fault), 32'd1);

    // A strobe while idle is ignored.
    adc_data  = 8'd0;
    adc_valid = 1'b1;
    cyc(1);
    adc_valid = 1'b0;
    sample(8'd220);
    chk("idle_valid_ignored", 32'(last_drop), 32'd5);

    // Trip again, then disable mid-request.
    sample(8'd210);
    chk("trip2_a", 32'(brownout), 32'd0);
    sample(8'd200);
    chk("trip2_b", 32'(brownout), 32'd1);
    wait_req();
    enable = 1'b0;
    cyc(1);
    chk("dis_req", 32'(adc_req), 32'd0);
    chk("dis_bo", 32'(brownout), 32'd0);
    chk("dis_fault", 32'(adc_fault), 32'd0);
    chk("dis_drop_hold", 32'(last_drop), 32'd10);
    enable = 1'b1;
    sample(8'd100);
    chk("reen_first_drop", 32'(last_drop), 32'd0);
    sample(8'd90);
    chk("reen_drop", 32'(last_drop), 32'd10);
    chk("reen_cnt_cleared", 32'(brownout), 32'd0);

    // Reset coinciding with a strobe discards it.
    wait_req();
    adc_data  = 8'd50;
    adc_valid = 1'b1;
    rst       = 1'b1;
    cyc(1);
    rst       = 1'b0;
    adc_valid = 1'b0;
    chk("rstv_req", 32'(adc_req), 32'd0);
    chk("rstv_bo", 32'(brownout), 32'd0);
    chk("rstv_fault", 32'(adc_fault), 32'd0);
    chk("rstv_drop", 32'(last_drop), 32'd0);
    adc_data  = 8'd255;
    adc_valid = 1'b1;
    cyc(1);
    adc_valid = 1'b0;
    chk("rstv_idle_req", 32'(adc_req), 32'd0);
    sample(8'd40);
    chk("rstv_first_drop", 32'(last_drop), 32'd0);
    sample(8'd35);
    chk("rstv_second_drop", 32'(last_drop), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
